// File: rtl/mem_arbiter.sv
// Two-port req/gnt arbiter in front of a single-port synchronous memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed CPU priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] data0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_last;
  logic                  r_hold_we;
  logic [ADDR_WIDTH-1:0] r_hold_addr;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_rv0;
  logic                  r_rv1;
  logic                  r_mem_we;

  logic                  w_any;
  logic                  w_win;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  assign w_any = req0 | req1;

  always_comb begin
    w_win = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention the port that did not win last time goes next.
    if (req0 & req1)
      w_win = ~r_last;
    else
      w_win = req1;
`else
    w_win = req1 & ~req0;
`endif
  end

  always_comb begin
    w_we   = we0;
    w_addr = addr0;
    w_data = data0;
    if (w_win) begin
      w_we   = we1;
      w_addr = addr1;
      w_data = data1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_hold_we   <= 1'b0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rv0       <= 1'b0;
      r_rv1       <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_rv0    <= 1'b0;
      r_rv1    <= 1'b0;
      r_mem_we <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner     <= w_win;
            r_last      <= w_win;
            r_hold_we   <= w_we;
            r_hold_addr <= w_addr;
            r_hold_data <= w_data;
            r_gnt0      <= ~w_win;
            r_gnt1      <= w_win;
            r_mem_we    <= w_we;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          r_rv0   <= ~r_hold_we & ~r_owner;
          r_rv1   <= ~r_hold_we & r_owner;
          r_state <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign rvalid0  = r_rv0;
  assign rvalid1  = r_rv1;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_hold_addr;
  assign mem_data = r_hold_data;
  assign rdata0   = mem_out;
  assign rdata1   = mem_out;

endmodule
